button_tick_gen: RTL and testbench

Upstream stage of the modulo-7 counter. It turns a raw, bouncing push-button into clean single-cycle count-enable pulses (tick). It also supports an optional auto-repeat while the button is held. With tick driving the counter's enable, seven confirmed presses wrap the counter from 0 back to 0.

---
 rtl/button_tick_gen.sv | 138 +++++++++++++
 tb/tb_button_tick_gen.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/button_tick_gen.sv
// Debounces a raw push-button into single-cycle count-enable ticks, with an
// optional auto-repeat while the button is held.
module button_tick_gen #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned HOLD_CYCLES     = 16,
  parameter int unsigned REPEAT_CYCLES   = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic button,
  input  logic repeat_en,
  output logic tick,
  output logic pressed
);

  typedef enum logic [1:0] {
    IDLE,
    DEB_PRESS,
    HELD,
    DEB_RELEASE
  } state_e;

  localparam logic [15:0] DebLast      = 16'(DEBOUNCE_CYCLES - 1);
  localparam logic [15:0] HoldLast     = 16'(HOLD_CYCLES - 1);
  // Reloading here after a repeat tick makes hcnt hit HoldLast again REPEAT_CYCLES later.
  localparam logic [15:0] RepeatReload = 16'(HOLD_CYCLES - REPEAT_CYCLES);

  logic        sync1_q, sync2_q;
  logic        btn_s;
  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] hcnt_q, hcnt_d;
  logic        tick_q, tick_d;
  logic        pressed_q, pressed_d;

  assign btn_s = sync2_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:        if (btn_s) state_d = DEB_PRESS;
      DEB_PRESS: begin
        if (!btn_s)                state_d = IDLE;
        else if (cnt_q == DebLast) state_d = HELD;
      end
      HELD:        if (!btn_s) state_d = DEB_RELEASE;
      DEB_RELEASE: begin
        if (btn_s)                 state_d = HELD;
        else if (cnt_q == DebLast) state_d = IDLE;
      end
      default:     state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d     = cnt_q;
    hcnt_d    = hcnt_q;
    tick_d    = 1'b0;
    pressed_d = pressed_q;
    unique case (state_q)
      IDLE: begin
        cnt_d  = '0;
        hcnt_d = '0;
      end
      DEB_PRESS: begin
        if (btn_s) begin
          if (cnt_q == DebLast) begin
            tick_d    = 1'b1;
            pressed_d = 1'b1;
            hcnt_d    = '0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      HELD: begin
        // A release on a tick-due cycle suppresses the tick.
        if (!btn_s) begin
          cnt_d  = '0;
          hcnt_d = '0;
        end else if (repeat_en) begin
          if (hcnt_q == HoldLast) begin
            tick_d = 1'b1;
            hcnt_d = RepeatReload;
          end else begin
            hcnt_d = hcnt_q + 16'd1;
          end
        end else begin
          hcnt_d = '0;
        end
      end
      DEB_RELEASE: begin
        if (btn_s) begin
          hcnt_d = '0;
        end else if (cnt_q == DebLast) begin
          pressed_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        cnt_d     = '0;
        hcnt_d    = '0;
        pressed_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      cnt_q     <= '0;
      hcnt_q    <= '0;
      tick_q    <= 1'b0;
      pressed_q <= 1'b0;
    end else begin
      sync1_q   <= button;
      sync2_q   <= sync1_q;
      cnt_q     <= cnt_d;
      hcnt_q    <= hcnt_d;
      tick_q    <= tick_d;
      pressed_q <= pressed_d;
    end
  end

  assign tick    = tick_q;
  assign pressed = pressed_q;

endmodule

// File: tb/tb_button_tick_gen.sv
// Directed bench for button_tick_gen: expected tick edges are queued when the
// stimulus is applied and matched against the DUT's ticks as they appear.
module tb_button_tick_gen;

  logic clock     = 1'b0;
  logic reset     = 1'b0;
  logic button    = 1'b1;
  logic repeat_en = 1'b0;
  logic tick;
  logic pressed;

  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;
  int   expQ[$];
  logic [2:0] modCount;

  button_tick_gen #(
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES    (16),
    .REPEAT_CYCLES  (8)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .button   (button),
    .repeat_en(repeat_en),
    .tick     (tick),
    .pressed  (pressed)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Downstream modulo-7 counter enabled by tick.
  always @(posedge clock or negedge reset) begin
    if (!reset)    modCount <= 3'd0;
    else if (tick) modCount <= (modCount == 3'd6) ? 3'd0 : modCount + 3'd1;
  end

  // Every observed tick must match the oldest queued expectation.
  always @(negedge clock) begin
    if (tick === 1'b1) begin
      checks++;
      assert (expQ.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_tick: observed tick at edge %0d, expected none", cyc);
      end
      if (expQ.size() != 0) begin
        int expEdge;
        expEdge = expQ.pop_front();
        checks++;
        assert (cyc === expEdge) else begin
          errors++;
          $error("FAIL tick_edge: observed edge=%0d expected edge=%0d", cyc, expEdge);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic waitEdges(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic applyStimulus(input logic b, input logic r);
    button    = b;
    repeat_en = r;
  endtask

  task automatic expectTick(input int offset);
    expQ.push_back(cyc + offset);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic pressAndRelease();
    applyStimulus(1'b1, 1'b0);
    expectTick(7);
    waitEdges(7);
    checkOutput("press_pressed", pressed, 1);
    waitEdges(8);
    applyStimulus(1'b0, 1'b0);
    waitEdges(7);
    checkOutput("release_pressed", pressed, 0);
    waitEdges(3);
  endtask

  initial begin
    $display("[TB] start");

    // Reset held with the button pressed: outputs stay low.
    for (int i = 0; i < 3; i++) begin
      waitEdges(1);
      checkOutput("reset_tick", tick, 0);
      checkOutput("reset_pressed", pressed, 0);
    end
    reset = 1'b1;
    expectTick(7);
    waitEdges(7);
    checkOutput("post_reset_pressed", pressed, 1);
    waitEdges(5);
    applyStimulus(1'b0, 1'b0);
    waitEdges(6);
    checkOutput("post_reset_release_early", pressed, 1);
    waitEdges(1);
    checkOutput("post_reset_release", pressed, 0);
    waitEdges(5);

    // Clean press held 20 cycles, no repeat.
    applyStimulus(1'b1, 1'b0);
    expectTick(7);
    waitEdges(6);
    checkOutput("clean_pressed_early", pressed, 0);
    waitEdges(1);
    checkOutput("clean_pressed", pressed, 1);
    waitEdges(13);
    applyStimulus(1'b0, 1'b0);
    waitEdges(6);
    checkOutput("clean_release_early", pressed, 1);
    waitEdges(1);
    checkOutput("clean_release", pressed, 0);
    waitEdges(5);

    // Bounce 1,1,0 three times, then steady press.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0); waitEdges(1);
      applyStimulus(1'b1, 1'b0); waitEdges(1);
      applyStimulus(1'b0, 1'b0); waitEdges(1);
    end
    checkOutput("bounce_pressed", pressed, 0);
    applyStimulus(1'b1, 1'b0);
    expectTick(7);
    waitEdges(7);
    checkOutput("bounce_steady_pressed", pressed, 1);
    waitEdges(5);
    applyStimulus(1'b0, 1'b0);
    waitEdges(10);
    checkOutput("bounce_release", pressed, 0);

    // Auto-repeat: first tick t0, then t0+16 and every 8 cycles.
    applyStimulus(1'b1, 1'b1);
    expectTick(7);
    expectTick(7 + 16);
    expectTick(7 + 24);
    expectTick(7 + 32);
    expectTick(7 + 40);
    expectTick(7 + 48);
    waitEdges(57);
    checkOutput("repeat_queue_drained", expQ.size(), 0);
    applyStimulus(1'b0, 1'b1);
    waitEdges(7);
    checkOutput("repeat_release", pressed, 0);
    applyStimulus(1'b0, 1'b0);
    waitEdges(3);

    // Release glitch: one-cycle return to 1 restarts the release debounce.
    applyStimulus(1'b1, 1'b0);
    expectTick(7);
    waitEdges(12);
    applyStimulus(1'b0, 1'b0); waitEdges(1);
    applyStimulus(1'b1, 1'b0); waitEdges(1);
    applyStimulus(1'b0, 1'b0);
    waitEdges(5);
    checkOutput("glitch_pressed_held", pressed, 1);
    waitEdges(2);
    checkOutput("glitch_release", pressed, 0);
    waitEdges(3);

    // Reset while debouncing a press (cnt=2): no tick, outputs cleared.
    applyStimulus(1'b1, 1'b0);
    waitEdges(5);
    reset = 1'b0;
    #1;
    checkOutput("midreset_tick", tick, 0);
    checkOutput("midreset_pressed", pressed, 0);
    waitEdges(2);
    applyStimulus(1'b0, 1'b0);
    waitEdges(2);
    reset = 1'b1;
    waitEdges(10);
    checkOutput("midreset_counter", modCount, 0);

    // Seven confirmed presses wrap the downstream counter back to 0.
    for (int i = 0; i < 7; i++) begin
      pressAndRelease();
      if (i == 2) checkOutput("counter_after3", modCount, 3);
    end
    checkOutput("counter_wrap", modCount, 0);
    checkOutput("final_queue_empty", expQ.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
